// File: rtl/cpu_tstate_seq.sv
// cpu_tstate_seq
//   Timing-state sequencer for the NES 6502 core. Latches the opcode on the
//   T0 fetch cycle, classifies it by the {aaa, bbb, cc} encoding and steps
//   T-states with exact 6502 cycle counts, including page-cross and
//   branch-taken penalties, RMW dummy/real writes, RDY stalls and the
//   post-reset startup sequence. Datapath control decodes on {tstate, ir}.
//
// Parameters
//   RESET_CYCLES  startup cycles after reset release before the first fetch (1-15)
//   RDY_ON_WRITE  0: rdy low is ignored on write cycles (NMOS); 1: rdy stalls every cycle
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous reset, active low
//   rdy           1 = advance, 0 = stall
//   d_in          data bus, opcode during T0
//   page_cross    low-byte address carry, sampled in page-cross decision cycles
//   branch_taken  branch condition, sampled in branch T1
//   tstate        current T-state 0-6
//   ir            latched opcode
//   sync          opcode fetch cycle (T0)
//   last          final cycle of the instruction (next cycle is T0)
//   write         current cycle is a bus write
//   in_reset      startup sequence in progress
module cpu_tstate_seq #(
  parameter int RESET_CYCLES = 7,
  parameter bit RDY_ON_WRITE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] d_in,
  input  logic       page_cross,
  input  logic       branch_taken,
  output logic [2:0] tstate,
  output logic [7:0] ir,
  output logic       sync,
  output logic       last,
  output logic       write,
  output logic       in_reset
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  localparam logic [3:0] RST_CNT  = 4'(RESET_CYCLES);
  localparam logic [7:0] IR_RESET = 8'hEA;

  tstate_e    tstate_q, tstate_d;
  logic [7:0] ir_q, ir_d;
  logic       in_reset_q, in_reset_d;
  logic [3:0] cnt_q, cnt_d;

  // Opcode fields and decoded timing attributes
  logic [2:0] aaa, bbb;
  logic [1:0] cc;
  logic       is_branch;  // relative branch: timing handled separately
  logic       pc_dec;     // fin_t is a page-cross decision cycle (+1 on carry)
  logic       wr_en;      // instruction has bus write cycles
  logic [2:0] fin_t;      // T-state of the final cycle without penalties
  logic [2:0] wr_t;       // first write T-state; writes continue to the end
  logic       hold;

  assign aaa = ir_q[7:5];
  assign bbb = ir_q[4:2];
  assign cc  = ir_q[1:0];

  // Instruction class decode. Anything not matched (including the single-byte
  // implied group and unofficial opcodes) keeps the 2-cycle default.
  always_comb begin
    is_branch = 1'b0;
    pc_dec    = 1'b0;
    wr_en     = 1'b0;
    fin_t     = 3'd1;
    wr_t      = 3'd7;
    if (ir_q[4:0] == 5'b10000) begin
      is_branch = 1'b1;
    end else if (cc == 2'b01) begin
      if (aaa == 3'b100) begin
        // STA: indexed modes always pay the page-cross cycle
        unique case (bbb)
          3'b000:  fin_t = 3'd5;  // (zp,X)
          3'b001:  fin_t = 3'd2;  // zp
          3'b010:  fin_t = 3'd1;  // no immediate store: 2-cycle NOP
          3'b011:  fin_t = 3'd3;  // abs
          3'b100:  fin_t = 3'd5;  // (zp),Y
          3'b101:  fin_t = 3'd3;  // zp,X
          3'b110:  fin_t = 3'd4;  // abs,Y
          default: fin_t = 3'd4;  // abs,X
        endcase
        wr_en = (bbb != 3'b010);
        wr_t  = fin_t;
      end else begin
        unique case (bbb)
          3'b000:  fin_t = 3'd5;
          3'b001:  fin_t = 3'd2;
          3'b010:  fin_t = 3'd1;
          3'b011:  fin_t = 3'd3;
          3'b100: begin
            fin_t  = 3'd4;        // (zp),Y decides at T4
            pc_dec = 1'b1;
          end
          3'b101:  fin_t = 3'd3;
          3'b110: begin
            fin_t  = 3'd3;        // abs,Y decides at T3
            pc_dec = 1'b1;
          end
          default: begin
            fin_t  = 3'd3;        // abs,X decides at T3
            pc_dec = 1'b1;
          end
        endcase
      end
    end else if (cc == 2'b10 && aaa != 3'b100 && aaa != 3'b101) begin
      // RMW memory modes: dummy write then real write in the last two cycles.
      // Accumulator mode and the remaining bbb values stay 2-cycle, no write.
      unique case (bbb)
        3'b001: begin fin_t = 3'd4; wr_en = 1'b1; wr_t = 3'd3; end
        3'b011: begin fin_t = 3'd5; wr_en = 1'b1; wr_t = 3'd4; end
        3'b101: begin fin_t = 3'd5; wr_en = 1'b1; wr_t = 3'd4; end
        3'b111: begin fin_t = 3'd6; wr_en = 1'b1; wr_t = 3'd5; end
        default: fin_t = 3'd1;
      endcase
    end
  end

  // Outputs and next state. ir still holds the previous opcode during T0, so
  // all instruction decode is masked there. The >= comparisons make any
  // out-of-range T-state terminate the instruction, which recovers to T0.
  always_comb begin
    tstate_d   = tstate_q;
    ir_d       = ir_q;
    in_reset_d = in_reset_q;
    cnt_d      = cnt_q;
    sync       = ~in_reset_q & (tstate_q == T0);
    last       = 1'b0;
    write      = 1'b0;

    if (!in_reset_q && tstate_q != T0) begin
      if (is_branch) begin
        last = ((tstate_q == T1) & ~branch_taken) |
               ((tstate_q == T2) & ~page_cross)   |
               (tstate_q >= T3);
      end else if (pc_dec) begin
        last = ((tstate_q == fin_t) & ~page_cross) | (tstate_q > fin_t);
      end else begin
        last = (tstate_q >= fin_t);
      end
      write = wr_en & (tstate_q >= wr_t);
    end

    // NMOS parts cannot be halted on a write cycle unless configured so
    hold = ~rdy & (~write | RDY_ON_WRITE);

    if (in_reset_q) begin
      // Startup countdown runs regardless of rdy
      cnt_d = cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        in_reset_d = 1'b0;
      end
    end else if (!hold) begin
      if (tstate_q == T0) begin
        ir_d     = d_in;
        tstate_d = T1;
      end else if (last) begin
        tstate_d = T0;
      end else begin
        tstate_d = tstate_e'(tstate_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tstate_q   <= T0;
      ir_q       <= IR_RESET;
      in_reset_q <= 1'b1;
      cnt_q      <= RST_CNT;
    end else begin
      tstate_q   <= tstate_d;
      ir_q       <= ir_d;
      in_reset_q <= in_reset_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tstate   = tstate_q;
  assign ir       = ir_q;
  assign in_reset = in_reset_q;

endmodule

// File: doc/cpu_tstate_seq.md
# cpu_tstate_seq

Parametrised timing-state sequencer for the NES 6502 core, generalising the cpu controller FSM's T0–T6 sequencing. It latches the opcode on the fetch cycle, decodes the instruction class and addressing mode, and steps T-states with exact 6502 cycle counts. Cycle counts include page-cross and branch-taken penalties, RMW double writes, an RDY stall input and a post-reset startup sequence. Downstream datapath control decodes on `{tstate, ir}`.

## Interface
Parameters:
- `RESET_CYCLES`, default 7: startup cycles after reset release before the first opcode fetch (range 1–15).
- `RDY_ON_WRITE`, default 0: 0 = `rdy` low is ignored on write cycles (NMOS behaviour); 1 = `rdy` stalls every cycle.

Ports:
- `clk`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `rdy`  in  1: 1 = advance; 0 = stall (see Operation).
- `d_in`  in  8: data bus; holds the opcode during T0.
- `page_cross`  in  1: carry out of the low-byte address add, sampled at decision cycles.
- `branch_taken`  in  1: branch condition result, sampled at branch T1.
- `tstate`  out  3: current T-state, 0–6.
- `ir`  out  8: latched opcode.
- `sync`  out  1: 1 during the T0 opcode-fetch cycle.
- `last`  out  1: 1 in the final cycle of an instruction (next cycle is T0).
- `write`  out  1: 1 when the current cycle is a bus write.
- `in_reset`  out  1: 1 during the startup sequence.

## Operation
- Reset (`rst`=0):
  - `tstate`=0, `ir`=8'hEA, `sync`=0, `last`=0, `write`=0, `in_reset`=1.
  - Startup counter is loaded with `RESET_CYCLES`.
  - Reset overrides everything, including mid-instruction.
- Startup:
  - After `rst` returns to 1, `in_reset` stays 1 for exactly `RESET_CYCLES` cycles.
  - The counter ignores `rdy`.
  - The following cycle is T0 with `sync`=1.
- T0: `sync`=1. On advance, `ir` <= `d_in` and `tstate` <= 1. T0 is never last.
- An instruction of N cycles occupies T0..T(N-1). `last`=1 in T(N-1), then the sequencer returns to T0.
- Cycle counts, 6502 encoding `ir` = {aaa, bbb, cc}:
  - Single-byte implied (CLC CLD CLI CLV DEX DEY INX INY NOP SEC SED SEI TAX TAY TSX TXA TXS TYA): 2.
  - cc=01, indexed by bbb:
    - (zp,X)=6, zp=3, imm=2, abs=4, zp,X=4.
    - (zp),Y=5, +1 if `page_cross` is sampled 1 at T4.
    - abs,Y=4 and abs,X=4, each +1 if `page_cross` is sampled 1 at T3.
    - STA (aaa=100) always takes the penalty: 6/3/—/4/6/4/5/5.
  - cc=10 RMW (aaa ∉ {100,101}): acc (bbb=010)=2, zp=5, abs=6, zp,X=6, abs,X=7 (fixed).
  - Branches (`ir`[4:0]=10000): 2. +1 if `branch_taken`=1 at T1. A further +1 if `page_cross`=1 at T2 of a taken branch.
  - Every other opcode executes as a 2-cycle NOP.
- Conditional inputs are sampled only in their decision cycle and only on an advancing edge; they are ignored otherwise.
- `write`=1:
  - In the last cycle of STA.
  - In the last two cycles of an RMW memory mode (dummy write, then real write).
  - Never for acc mode.
- RDY:
  - If `rdy`=0 and (`write`=0 or `RDY_ON_WRITE`=1), all state is held.
  - During a hold, outputs stay constant and sampled inputs are ignored.
  - A stall in T0 keeps `sync`=1 and re-captures `d_in` when `rdy` rises.

## Timing
- Outputs are registered state or pure decode of `tstate`/`ir`. No combinational path from `d_in` to outputs.
- `last` does depend combinationally on `page_cross`/`branch_taken` in decision cycles; the sampled value decides the next state on the same edge.
- Minimum instruction is 2 cycles. Back-to-back instructions have zero bubble: T(N-1) is followed directly by T0.
- `tstate` never exceeds 6; an illegal value recovers to T0 on the next advance.

## Test plan
- Reset release, `RESET_CYCLES`=7, `rdy`=1:
  - `in_reset`=1 for 7 cycles, then `sync`=1.
  - `d_in`=8'hA9 gives T0,T1 (`last`) then T0.
- LDA abs,X (8'hBD):
  - `page_cross`=0 at T3 → 4 cycles.
  - `page_cross`=1 → 5 cycles.
  - STA abs,X (8'h9D) → 5 cycles regardless of `page_cross`.
- INC abs,X (8'hFE): 7 cycles, with `write`=1 at T5 and T6 only.
- Branch BNE (8'hD0):
  - not taken → 2 cycles.
  - taken, no page cross → 3 cycles.
  - taken with page cross → 4 cycles.
- `rdy`=0 for 3 cycles at T2 of LDA zp (8'hA5): `tstate` holds at 2, and the instruction completes 3 cycles late.
- `rdy`=0 at the final write cycle of STA zp (8'h85):
  - `RDY_ON_WRITE`=0 → advances.
  - `RDY_ON_WRITE`=1 → holds.
- `rst`=0 asserted at T4 of 8'hFE: next cycle `tstate`=0, `ir`=8'hEA, `in_reset`=1.
